// File: rtl/audio_tone_gen.sv
// audio_tone_gen
//   Multi-channel audio test-tone source for the HDMI output path, clocked
//   entirely by clk_pixel. An exact integer divider sets the sample rate and
//   drives a registered clk_audio square wave. Each channel has its own phase
//   accumulator; all channels share one waveform select (saw, square,
//   triangle, silence).
//   Optional feature: define AUDIO_TONE_TRIANGLE_EN to build the triangle
//   waveform for mode 2. Without it, mode 2 outputs 0 like mode 3.
module audio_tone_gen #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned CLK_HZ      = 25200000,
  parameter int unsigned SAMPLE_RATE = 48000
) (
  input  logic                            clk_pixel,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [1:0]                      mode,
  input  logic                            sync,
  input  logic [CHANNELS*PHASE_WIDTH-1:0] increment,
  output logic                            sample_strobe,
  output logic                            clk_audio,
  output logic [CHANNELS*BIT_WIDTH-1:0]   audio_sample_word
);

  localparam int unsigned DIV   = CLK_HZ / SAMPLE_RATE;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);

  // Square levels are symmetric: +(M-1) and -(M-1), with M = 1 << (BIT_WIDTH-1).
  localparam logic [BIT_WIDTH-1:0] SAMPLE_MSB = BIT_WIDTH'(1) << (BIT_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0] SQ_POS     = SAMPLE_MSB - BIT_WIDTH'(1);
  localparam logic [BIT_WIDTH-1:0] SQ_NEG     = BIT_WIDTH'(0) - SQ_POS;

  // Elaboration-time parameter checks.
  generate
    if ((CLK_HZ % SAMPLE_RATE) != 0 || DIV < 4) begin : g_bad_div
      $error("audio_tone_gen: CLK_HZ / SAMPLE_RATE must be an exact integer >= 4");
    end
    if (BIT_WIDTH > PHASE_WIDTH || BIT_WIDTH < 2) begin : g_bad_width
      $error("audio_tone_gen: BIT_WIDTH must be in [2, PHASE_WIDTH]");
    end
    if (CHANNELS < 1) begin : g_bad_channels
      $error("audio_tone_gen: CHANNELS must be at least 1");
    end
  endgenerate

  // Top BIT_WIDTH bits of a phase-width value.
  function automatic logic [BIT_WIDTH-1:0] top_bits(input logic [PHASE_WIDTH-1:0] v);
    return v[PHASE_WIDTH-1 -: BIT_WIDTH];
  endfunction

`ifdef AUDIO_TONE_TRIANGLE_EN
  // Triangle: fold the lower phase bits on the MSB, double, and offset to
  // two's complement by flipping the sample MSB.
  function automatic logic [BIT_WIDTH-1:0] tri_wave(input logic [PHASE_WIDTH-1:0] p);
    logic [PHASE_WIDTH-2:0] fold;
    logic [PHASE_WIDTH-1:0] u;
    fold = p[PHASE_WIDTH-1] ? ~p[PHASE_WIDTH-2:0] : p[PHASE_WIDTH-2:0];
    u    = {fold, 1'b0};
    return top_bits(u) ^ SAMPLE_MSB;
  endfunction
`endif

  // Waveform generator shared by all channels.
  function automatic logic [BIT_WIDTH-1:0] wave(input logic [1:0]             m,
                                                input logic [PHASE_WIDTH-1:0] p);
    logic [BIT_WIDTH-1:0] w;
    w = '0;
    case (m)
      2'd0:    w = top_bits(p);
      2'd1:    w = p[PHASE_WIDTH-1] ? SQ_NEG : SQ_POS;
`ifdef AUDIO_TONE_TRIANGLE_EN
      2'd2:    w = tri_wave(p);
`endif
      default: w = '0;
    endcase
    return w;
  endfunction

  logic [DIV_W-1:0]       div_q;
  logic [DIV_W-1:0]       div_nxt;
  logic                   strobe;
  logic                   sync_pend_q;
  logic                   sync_now;
  logic [PHASE_WIDTH-1:0] phase_q   [CHANNELS];
  logic [PHASE_WIDTH-1:0] phase_eff [CHANNELS];
  logic [PHASE_WIDTH-1:0] phase_nxt [CHANNELS];
  logic [CHANNELS*BIT_WIDTH-1:0] sample_nxt;

  assign strobe        = (div_q == DIV_LAST);
  assign div_nxt       = strobe ? '0 : div_q + DIV_W'(1);
  assign sample_strobe = strobe;
  assign sync_now      = sync_pend_q | sync;

  // Sample-rate divider and registered clk_audio (high for the upper half of
  // the count, decoded from the next count so it stays glitch-free).
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      clk_audio <= 1'b0;
    end else begin
      div_q     <= div_nxt;
      clk_audio <= (div_nxt >= DIV_HALF);
    end
  end

  // Sync requests between strobes collapse into one pending flag.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      sync_pend_q <= 1'b0;
    end else if (strobe) begin
      sync_pend_q <= 1'b0;
    end else if (sync) begin
      sync_pend_q <= 1'b1;
    end
  end

  // Per-channel effective phase, next phase and next sample.
  always_comb begin
    phase_eff  = '{default: '0};
    phase_nxt  = '{default: '0};
    sample_nxt = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      phase_eff[c] = sync_now ? '0 : phase_q[c];
      phase_nxt[c] = enable ? phase_eff[c] + increment[c*PHASE_WIDTH +: PHASE_WIDTH]
                            : phase_eff[c];
      sample_nxt[c*BIT_WIDTH +: BIT_WIDTH] = wave(mode, phase_eff[c]);
    end
  end

  // Phase accumulators and sample registers update only at the strobe edge.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        phase_q[c] <= '0;
      end
      audio_sample_word <= '0;
    end else if (strobe) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        phase_q[c] <= phase_nxt[c];
      end
      audio_sample_word <= sample_nxt;
    end
  end

endmodule

// File: tb/tb_audio_tone_gen.sv
// tb_audio_tone_gen: table-driven check of audio_tone_gen at DIV = 8 with a
// scoreboard of expected sample words, plus hand sequences for divider
// timing and asynchronous reset.
module tb_audio_tone_gen;

`ifdef AUDIO_TONE_TRIANGLE_EN
  localparam bit TRI_ON = 1'b1;
`else
  localparam bit TRI_ON = 1'b0;
`endif

  logic        clk_pixel = 1'b0;
  logic        reset     = 1'b0;
  logic        enable    = 1'b1;
  logic [1:0]  mode      = 2'd0;
  logic        sync      = 1'b0;
  logic [31:0] increment = '0;
  logic        sample_strobe;
  logic        clk_audio;
  logic [31:0] audio_sample_word;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [31:0] sb [$];

  // sk: 0 none, 1 sync only in the strobe cycle, 2 one pulse mid-period,
  //     3 two pulses mid-period. gl: mode/increment disturbed mid-period.
  typedef struct {
    logic [1:0]  m;
    logic        en;
    logic [1:0]  sk;
    logic        gl;
    logic [15:0] inc0;
    logic [15:0] inc1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t vecs [$];

  audio_tone_gen #(
    .CHANNELS    (2),
    .BIT_WIDTH   (16),
    .PHASE_WIDTH (16),
    .CLK_HZ      (384000),
    .SAMPLE_RATE (48000)
  ) dut (
    .clk_pixel         (clk_pixel),
    .reset             (reset),
    .enable            (enable),
    .mode              (mode),
    .sync              (sync),
    .increment         (increment),
    .sample_strobe     (sample_strobe),
    .clk_audio         (clk_audio),
    .audio_sample_word (audio_sample_word)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  function automatic vec_t mk(input logic [1:0] m, input logic en, input logic [1:0] sk,
                              input logic gl, input logic [15:0] i0, input logic [15:0] i1,
                              input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.m = m; v.en = en; v.sk = sk; v.gl = gl;
    v.inc0 = i0; v.inc1 = i1; v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  function automatic logic [15:0] tri_exp(input logic [15:0] v);
    return TRI_ON ? v : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_vec(input int idx, input vec_t v);
    int unsigned n;
    bit          seen;
    logic [31:0] exp_w;
    mode      = v.m;
    enable    = v.en;
    increment = {v.inc1, v.inc0};
    sb.push_back({v.exp1, v.exp0});
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk_pixel);
      n++;
      sync = 1'b0;
      if (v.sk == 2'd2 && n == 3) sync = 1'b1;
      if (v.sk == 2'd3 && (n == 2 || n == 4)) sync = 1'b1;
      if (v.gl && n == 3) begin
        mode      = ~v.m;
        increment = ~{v.inc1, v.inc0};
      end
      if (v.gl && n == 5) begin
        mode      = v.m;
        increment = {v.inc1, v.inc0};
      end
      if (sample_strobe) begin
        seen = 1'b1;
        if (v.sk == 2'd1) sync = 1'b1;
      end
    end
    exp_w = sb.pop_front();
    if (!seen) begin
      check($sformatf("strobe_timeout_vec%0d", idx), 32'd0, 32'd1);
    end else begin
      @(posedge clk_pixel);
      #1;
      sync = 1'b0;
      check($sformatf("sample_vec%0d", idx), audio_sample_word, exp_w);
    end
  endtask

  initial begin
    int unsigned k;

    // Saw, then mid-period and coincident sync, with a disturbed period.
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0000, 16'h0000));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0600, 16'h1200));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0C00, 16'h2400));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h1200, 16'h3600));
    vecs.push_back(mk(2'd0, 1'b1, 2'd2, 1'b0, 16'h0600, 16'h1200, 16'h0000, 16'h0000));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0600, 16'h1200));
    vecs.push_back(mk(2'd0, 1'b1, 2'd1, 1'b0, 16'h0600, 16'h1200, 16'h0000, 16'h0000));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b1, 16'h0600, 16'h1200, 16'h0600, 16'h1200));
    // Saw wrap.
    vecs.push_back(mk(2'd0, 1'b1, 2'd1, 1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h0000));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h0000));
    // Square.
    vecs.push_back(mk(2'd1, 1'b1, 2'd1, 1'b0, 16'h4000, 16'hC000, 16'h7FFF, 16'h7FFF));
    vecs.push_back(mk(2'd1, 1'b1, 2'd0, 1'b1, 16'h4000, 16'hC000, 16'h7FFF, 16'h8001));
    vecs.push_back(mk(2'd1, 1'b1, 2'd0, 1'b0, 16'h4000, 16'hC000, 16'h8001, 16'h8001));
    vecs.push_back(mk(2'd1, 1'b1, 2'd0, 1'b0, 16'h4000, 16'hC000, 16'h8001, 16'h7FFF));
    vecs.push_back(mk(2'd1, 1'b1, 2'd0, 1'b0, 16'h4000, 16'hC000, 16'h7FFF, 16'h7FFF));
    // Triangle (silent when the feature is not built).
    vecs.push_back(mk(2'd2, 1'b1, 2'd1, 1'b0, 16'h4000, 16'hC000, tri_exp(16'h8000), tri_exp(16'h8000)));
    vecs.push_back(mk(2'd2, 1'b1, 2'd0, 1'b0, 16'h4000, 16'hC000, tri_exp(16'h0000), tri_exp(16'hFFFE)));
    vecs.push_back(mk(2'd2, 1'b1, 2'd0, 1'b0, 16'h4000, 16'hC000, tri_exp(16'h7FFE), tri_exp(16'h7FFE)));
    vecs.push_back(mk(2'd2, 1'b1, 2'd0, 1'b0, 16'h4000, 16'hC000, tri_exp(16'hFFFE), tri_exp(16'h0000)));
    // Silence keeps advancing the phase; saw resumes continuously.
    vecs.push_back(mk(2'd3, 1'b1, 2'd0, 1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h0000));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h4000, 16'h4000, 16'h4000, 16'h4000));
    // Collapsed double sync, then enable hold and resume.
    vecs.push_back(mk(2'd0, 1'b1, 2'd3, 1'b0, 16'h0600, 16'h1200, 16'h0000, 16'h0000));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0600, 16'h1200));
    vecs.push_back(mk(2'd0, 1'b0, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0C00, 16'h2400));
    vecs.push_back(mk(2'd0, 1'b0, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0C00, 16'h2400));
    vecs.push_back(mk(2'd0, 1'b0, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0C00, 16'h2400));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h0C00, 16'h2400));
    vecs.push_back(mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h1200, 16'h1200, 16'h3600));

    // Reset state.
    #1 reset = 1'b1;
    #1;
    check("reset_word", audio_sample_word, 32'h0);
    check("reset_strobe", {31'd0, sample_strobe}, 32'd0);
    check("reset_clk_audio", {31'd0, clk_audio}, 32'd0);

    // Divider timing: strobe on count 7, clk_audio high on counts 4..7.
    @(negedge clk_pixel);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      check($sformatf("clk_audio_cyc%0d", i), {31'd0, clk_audio}, {31'd0, (i % 8) >= 4});
      check($sformatf("strobe_cyc%0d", i), {31'd0, sample_strobe}, {31'd0, (i % 8) == 7});
      @(negedge clk_pixel);
    end

    foreach (vecs[i]) do_vec(i, vecs[i]);

    // Asynchronous reset between clock edges while clk_audio is high.
    repeat (5) @(posedge clk_pixel);
    #3;
    check("pre_reset_clk_audio", {31'd0, clk_audio}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_word", audio_sample_word, 32'h0);
    check("async_reset_clk_audio", {31'd0, clk_audio}, 32'd0);
    check("async_reset_strobe", {31'd0, sample_strobe}, 32'd0);
    repeat (2) @(negedge clk_pixel);
    mode      = 2'd0;
    enable    = 1'b1;
    increment = {16'h0600, 16'h0600};
    reset     = 1'b0;
    k = 0;
    while (!sample_strobe && k < 20) begin
      @(negedge clk_pixel);
      k++;
    end
    check("first_strobe_delay", k, 32'd7);
    @(posedge clk_pixel);
    #1;
    check("first_sample_after_reset", audio_sample_word, 32'h0);
    do_vec(100, mk(2'd0, 1'b1, 2'd0, 1'b0, 16'h0600, 16'h0600, 16'h0600, 16'h0600));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_tone_gen.md
# audio_tone_gen

Parametrised multi-channel audio test-tone source for the HDMI output path. Runs entirely on `clk_pixel`. Derives the audio sample rate with an exact integer divider and produces a `clk_audio` square wave for the HDMI core's audio input. Each channel has its own phase accumulator and selectable waveform, replacing the fixed two-channel sawtooth used for bring-up.

## Interface
- `CHANNELS`, default 2: number of audio channels.
- `BIT_WIDTH`, default 16: sample width, two's complement; must be ≤ `PHASE_WIDTH`.
- `PHASE_WIDTH`, default 16: accumulator and increment width.
- `CLK_HZ`, default 25200000: `clk_pixel` frequency.
- `SAMPLE_RATE`, default 48000; `DIV = CLK_HZ / SAMPLE_RATE` (525 at defaults) must be an exact integer ≥ 4; an elaboration-time check enforces this.

Ports:
- `clk_pixel`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  1 = accumulators advance; 0 = phases hold.
- `mode`  in  2  waveform for all channels: 0 saw, 1 square, 2 triangle, 3 silence.
- `sync`  in  1  request to zero every phase at the next sample point.
- `increment`  in  `CHANNELS*PHASE_WIDTH`  per-channel phase step, channel c at bits `[c*PHASE_WIDTH +: PHASE_WIDTH]`.
- `sample_strobe`  out  1  one-cycle pulse per sample period.
- `clk_audio`  out  1  registered square wave at `SAMPLE_RATE`.
- `audio_sample_word`  out  `CHANNELS*BIT_WIDTH`  current samples, channel c at `[c*BIT_WIDTH +: BIT_WIDTH]`.

## Operation
- Divider counts 0..`DIV`-1 and wraps.
- `sample_strobe` is high exactly while divider == `DIV`-1.
- At the strobe edge, for each channel:
  - Effective phase p = 0 if a sync is pending or `sync` is high this cycle; otherwise p = the stored phase.
  - The sample register is loaded with f(p).
  - The phase register is loaded with p + increment (mod 2^`PHASE_WIDTH`) if `enable`, otherwise p.
  - The pending sync flag clears.
- `sync` asserted in any non-strobe cycle sets the pending flag, which holds until the next strobe. Multiple requests collapse into one.
- `mode` and `increment` are sampled only at the strobe edge. Changes between strobes have no effect on outputs.
- Waveforms, with T = top `BIT_WIDTH` bits of a `PHASE_WIDTH`-bit value and M = `1 << (BIT_WIDTH-1)`:
  - Saw: T(p).
  - Square: p MSB 0 → M-1; MSB 1 → -(M-1).
  - Triangle: fold = MSB ? ~p[PW-2:0] : p[PW-2:0]; u = {fold, 1'b0}; sample = T(u) ^ M.
  - Silence: 0. Phase keeps advancing so that resuming is phase-continuous.
- Divider, strobe and `clk_audio` run regardless of `enable` or `mode`.

## Timing
- Reset values: divider 0, all phases 0, pending sync 0, `audio_sample_word` 0, `sample_strobe` 0, `clk_audio` 0.
- `clk_audio` is high while divider ∈ [`DIV`/2, `DIV`-1]. It is driven from a register (no combinational glitch) and rises `DIV`/2 cycles after each sample update.
- Samples change only at the strobe edge, so they are stable for at least `DIV`/2 cycles either side of each `clk_audio` rising edge.
- Sample latency: sample k (k = 0, 1, …) becomes visible on the edge ending the k-th strobe. After reset, the first strobe occurs `DIV` cycles after reset release and yields f(0).
- Reset mid-operation returns every register to its reset value immediately, independent of the clock.

## Configuration
- `AUDIO_TONE_TRIANGLE_EN` defined: mode 2 produces the triangle waveform.
- Not defined: triangle logic is absent and mode 2 behaves exactly as mode 3 (output 0, phase advances).

## Test plan
All scenarios use `CLK_HZ` = 384000 (`DIV` = 8) and default widths.
- Saw: `enable`=1, `mode`=0, inc0 = 0x0600, inc1 = 0x1200 → strobe every 8 cycles; ch0 = 0x0000, 0x0600, 0x0C00, …; ch1 = 0x0000, 0x1200, 0x2400, …; `clk_audio` high during divider 4..7.
- Wrap and square: inc = 0x8000 in saw → 0x0000, 0x8000, 0x0000; inc = 0x4000 in square → 0x7FFF, 0x7FFF, 0x8001, 0x8001, repeating.
- Triangle (macro defined): inc = 0x4000 → 0x8000, 0x0000, 0x7FFE, 0xFFFE, repeating. Macro undefined: all outputs 0x0000.
- `sync` pulsed mid-period with inc = 0x0600, phase at 0x1800 → next sample 0x0000, following 0x0600. `sync` coincident with the strobe gives the same result.
- `enable`=0 after three saw samples → output holds 0x0C00 indefinitely. Re-enable → 0x0C00, then 0x1200.
- `reset` asserted mid-period between clock edges → all outputs 0 immediately. After release, the first strobe comes 8 cycles later with sample 0x0000.
